pipe_stage_skid: RTL and testbench



---
 rtl/pipe_pkg.sv | 40 ++++
 rtl/pipe_stage_skid_slot.sv | 57 +++++
 rtl/pipe_stage_skid.sv | 105 ++++++++++
 tb/tb_pipe_stage_skid.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage core pipeline boundaries.
//   - CTRL field offsets inside the control payload
//   - per-boundary payload widths
//   - NOP control word and the occupancy state type used by pipe_stage_skid
package pipe_pkg;

  // Control payload field layout (bits 10..11 are spare).
  localparam int ALUOP_LSB   = 0;
  localparam int ALUOP_W     = 4;
  localparam int MEMRD_BIT   = 4;
  localparam int MEMWR_BIT   = 5;
  localparam int REGWR_BIT   = 6;
  localparam int MEM2REG_BIT = 7;
  localparam int REGDST_BIT  = 8;
  localparam int ALUSRC_BIT  = 9;

  localparam int DATA_W_DEF  = 128;
  localparam int CTRL_W_DEF  = 12;

  // Per-boundary payload widths.
  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 12;
  localparam int IDEX_DATA_W  = 128;
  localparam int IDEX_CTRL_W  = 12;
  localparam int EXMEM_DATA_W = 101;
  localparam int EXMEM_CTRL_W = 12;
  localparam int MEMWB_DATA_W = 69;
  localparam int MEMWB_CTRL_W = 12;

  // All-zero control word is a pipeline bubble.
  localparam logic [CTRL_W_DEF-1:0] NOP_CTRL = '0;

  // Stage state is fully described by how many beats it holds.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_FULL1 = 2'd1,
    OCC_FULL2 = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// pipe_slot: one pipeline entry (valid + data + ctrl).
//   clk, rst_n      : clock, async active-low reset
//   load_i          : capture data_i/ctrl_i and mark valid
//   clr_i           : drop the entry: valid and ctrl go to 0, data is kept
//                     (wins over load_i)
//   valid_o/data_o/ctrl_o : registered entry contents
module pipe_slot #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clr_i) begin
      // Clearing ctrl here is what makes an empty slot read as a NOP.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: parametrised pipeline boundary register.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : upstream handshake, beat accepted when both high
//   in_data/in_ctrl      : upstream payload (sampled only on accept)
//   flush                : synchronous squash of all held beats
//   out_valid/out_ready  : downstream handshake, hand-off when both high
//   out_data/out_ctrl    : presented payload; out_ctrl is 0 whenever out_valid=0
//   occupancy            : number of held beats (0..2)
// Handshake: a beat moves across an interface in any cycle where valid and
// ready are both high; a presented beat stays stable until it moves or is
// flushed. SKID=1 adds a second entry so in_ready is a register plus one gate
// with no path from out_ready; SKID=0 is a single entry with a combinational
// ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 12,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic              main_load, main_clr;
  logic [DATA_W-1:0] main_din;
  logic [CTRL_W-1:0] main_cin;
  logic              accept, handoff;
  occ_e              occ_state;

  assign accept  = in_valid & in_ready;
  assign handoff = main_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_valid;
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;
      logic              skid_load, skid_clr;

      assign in_ready = !skid_valid & !flush;

      // A held skid beat is always next in line; in_ready is 0 then, so the
      // input cannot compete for the main entry.
      assign main_load = skid_valid ? out_ready : (accept & (!main_valid | out_ready));
      assign main_din  = skid_valid ? skid_data : in_data;
      assign main_cin  = skid_valid ? skid_ctrl : in_ctrl;
      assign main_clr  = flush | (handoff & !main_load);

      // Park the new beat only when main is busy and not draining.
      assign skid_load = accept & main_valid & !out_ready;
      assign skid_clr  = flush | (skid_valid & out_ready);

      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clr_i   (skid_clr),
        .data_i  (in_data),
        .ctrl_i  (in_ctrl),
        .valid_o (skid_valid),
        .data_o  (skid_data),
        .ctrl_o  (skid_ctrl)
      );

      assign occ_state = occ_e'({1'b0, main_valid} + {1'b0, skid_valid});
    end else begin : g_noskid
      assign in_ready  = (!main_valid | out_ready) & !flush;
      assign main_load = accept;
      assign main_din  = in_data;
      assign main_cin  = in_ctrl;
      assign main_clr  = flush | (handoff & !accept);
      assign occ_state = occ_e'({1'b0, main_valid});
    end
  endgenerate

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (main_load),
    .clr_i   (main_clr),
    .data_i  (main_din),
    .ctrl_i  (main_cin),
    .valid_o (main_valid),
    .data_o  (out_data),
    .ctrl_o  (main_ctrl)
  );

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign occupancy = occ_state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance share the
// same input stimulus; each is compared every cycle against a FIFO-queue
// reference model of its own.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int CW = 12;
  localparam int W  = DW + CW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared inputs ----------------
  logic          in_valid  = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic [CW-1:0] in_ctrl   = '0;
  logic          flush     = 1'b0;
  logic          out_ready = 1'b0;

  // SKID=1 instance outputs
  logic          a_in_ready, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [CW-1:0] a_out_ctrl;
  logic [1:0]    a_occ;
  // SKID=0 instance outputs
  logic          b_in_ready, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [CW-1:0] b_out_ctrl;
  logic [1:0]    b_occ;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .occupancy(a_occ)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .occupancy(b_occ)
  );

  // ---------------- scoreboard / model ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  // Held beats as {ctrl, data}, head is the presented one.
  logic [W-1:0]  exp_q1[$];
  logic [W-1:0]  exp_q0[$];
  // Data of the most recent beat to reach the head: what out_data shows when empty.
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] last0 = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q1.delete();
    exp_q0.delete();
    last1 = '0;
    last0 = '0;
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] h;
    // SKID=1: capacity two, ready depends only on free space and flush
    if (exp_q1.size() != 0) h = exp_q1[0];
    else                    h = {NOP_CTRL, last1};
    check({tag, ".a_in_ready"},  a_in_ready,  (exp_q1.size() < 2) && !flush);
    check({tag, ".a_out_valid"}, a_out_valid, exp_q1.size() != 0);
    check({tag, ".a_out_data"},  a_out_data,  h[DW-1:0]);
    check({tag, ".a_out_ctrl"},  a_out_ctrl,  h[W-1:DW]);
    check({tag, ".a_occ"},       a_occ,       exp_q1.size());
    // SKID=0: capacity one, may accept while the held beat leaves
    if (exp_q0.size() != 0) h = exp_q0[0];
    else                    h = {NOP_CTRL, last0};
    check({tag, ".b_in_ready"},  b_in_ready,  (exp_q0.size() == 0 || out_ready) && !flush);
    check({tag, ".b_out_valid"}, b_out_valid, exp_q0.size() != 0);
    check({tag, ".b_out_data"},  b_out_data,  h[DW-1:0]);
    check({tag, ".b_out_ctrl"},  b_out_ctrl,  h[W-1:DW]);
    check({tag, ".b_occ"},       b_occ,       exp_q0.size());
  endtask

  // Advance both models across one rising edge with the current inputs.
  task automatic model_update();
    bit acc1, acc0, hs1, hs0;
    logic [W-1:0] h;
    acc1 = in_valid && (exp_q1.size() < 2) && !flush;
    hs1  = (exp_q1.size() != 0) && out_ready;
    acc0 = in_valid && (exp_q0.size() == 0 || out_ready) && !flush;
    hs0  = (exp_q0.size() != 0) && out_ready;
    if (flush) begin
      exp_q1.delete();
      exp_q0.delete();
    end else begin
      if (hs1)  void'(exp_q1.pop_front());
      if (acc1) exp_q1.push_back({in_ctrl, in_data});
      if (hs0)  void'(exp_q0.pop_front());
      if (acc0) exp_q0.push_back({in_ctrl, in_data});
    end
    if (exp_q1.size() != 0) begin h = exp_q1[0]; last1 = h[DW-1:0]; end
    if (exp_q0.size() != 0) begin h = exp_q0[0]; last0 = h[DW-1:0]; end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic fl, input logic rdy);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    flush     = fl;
    out_ready = rdy;
  endtask

  // Inputs are set at the falling edge; check, then cross one rising edge.
  task automatic step(input string tag);
    #1;
    check_all(tag);
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held three cycles with a live input beat.
    #1;
    rst_n = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 12'hFFF, 1'b0, 1'b1);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst.a_out_valid", a_out_valid, 1'b0);
      check("rst.a_out_ctrl",  a_out_ctrl,  NOP_CTRL);
      check("rst.a_occ",       a_occ,       2'd0);
      check("rst.b_out_valid", b_out_valid, 1'b0);
      check("rst.b_out_ctrl",  b_out_ctrl,  NOP_CTRL);
      check("rst.b_occ",       b_occ,       2'd0);
    end
    rst_n = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step("post_rst");

    // Streaming 1..8 with out_ready held high.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 12'h0A5, 1'b0, 1'b1);
      step("stream");
    end
    // Bubble: input idles, last beat drains, data stays, ctrl reads 0.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h5555_5555, 12'h3C3, 1'b0, 1'b1);
      step("bubble");
    end

    // Backpressure: A then B while downstream stalls.
    drive(1'b1, 32'h0000_00AA, 12'h011, 1'b0, 1'b0); step("bp_a");
    drive(1'b1, 32'h0000_00BB, 12'h022, 1'b0, 1'b0); step("bp_b");
    drive(1'b1, 32'h0000_00CC, 12'h033, 1'b0, 1'b0); step("bp_full");
    drive(1'b0, '0, '0, 1'b0, 1'b0);                 step("bp_hold");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      step("bp_drain");
    end

    // Flush while the skid instance holds two beats.
    drive(1'b1, 32'h0000_0111, 12'h101, 1'b0, 1'b0); step("fl_a");
    drive(1'b1, 32'h0000_0222, 12'h202, 1'b0, 1'b0); step("fl_b");
    drive(1'b1, 32'h0000_0333, 12'hFFF, 1'b1, 1'b1); step("fl_cyc");
    drive(1'b0, '0, '0, 1'b0, 1'b1);                 step("fl_after");

    // Single-entry replacement under a stall that lifts with a new beat.
    drive(1'b1, 32'h0000_0A0A, 12'h00F, 1'b0, 1'b0); step("rep_fill");
    drive(1'b1, 32'h0000_0B0B, 12'h0F0, 1'b0, 1'b0); step("rep_stall");
    drive(1'b1, 32'h0000_0C0C, 12'h0FF, 1'b0, 1'b1); step("rep_go");
    drive(1'b0, '0, '0, 1'b0, 1'b1);                 step("rep_after");
    drive(1'b0, '0, '0, 1'b0, 1'b1);                 step("rep_idle");

    // Randomized traffic with occasional flushes and one async reset.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, CW'($urandom),
            $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
      if (i == 300) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        #1;
        rst_n = 1'b1;
      end
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
